alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 The block SHALL have a port `clk`: input, 1 bit; the single clock, all state updates on its rising edge.
REQ-002 The block SHALL have a port `reset`: input, 1 bit; synchronous, active-high reset.
REQ-003 The block SHALL have a port `instr_valid`: input, 1 bit; an instruction word is offered.
REQ-004 The block SHALL have a port `instr`: input, 16 bits; [15:12] ALU opcode, [11:8] Rdest index, [7:4] Rsrc index, [3:0] reserved/ignored.
REQ-005 The block SHALL have a port `instr_ready`: output, 1 bit; the block can accept an instruction this cycle.
REQ-006 The block SHALL have a port `alu_opcode`: output, 4 bits; opcode driven to the external ALU.
REQ-007 The block SHALL have ports `alu_rsrc` and `alu_rdest`: output, 16 bits each; operands driven to the ALU.
REQ-008 The block SHALL have ports `alu_out` (input, 16 bits) and `alu_flags` (input, 5 bits); the ALU result and flags {N,Z,F,L,C} = bits [4:0].
REQ-009 The block SHALL have a port `psr`: output, 5 bits; the registered processor status flags, same bit order as `alu_flags`.
REQ-010 The block SHALL have ports `wb_valid` (output, 1 bit), `wb_addr` (output, 4 bits) and `wb_data` (output, 16 bits); a one-cycle writeback strobe with its register index and data.
REQ-011 The block SHALL have a port `illegal`: output, 1 bit; one-cycle pulse for opcode > 4'b1010.
REQ-012 The block SHALL have ports `dbg_addr` (input, 4 bits) and `dbg_data` (output, 16 bits); combinational read of the register file.

Function
REQ-013 The block SHALL contain a 16x16-bit register file, all entries writable, including R0.
REQ-014 The FSM SHALL have states IDLE, READ, EXEC, WB; transitions are IDLE->READ on `instr_valid & instr_ready`, READ->EXEC, EXEC->WB, WB->IDLE, all unconditional.
REQ-015 `instr_ready` SHALL be 1 only in IDLE; the instruction is latched on the accepting edge.
REQ-016 READ SHALL latch RF[Rsrc] and RF[Rdest] into operand registers; when Rsrc == Rdest, both latches SHALL receive the same value.
REQ-017 In EXEC, `alu_opcode`, `alu_rsrc` and `alu_rdest` SHALL drive the latched values, and `alu_out` and `alu_flags` SHALL be sampled at the end of EXEC; in all other states the ALU outputs SHALL hold their last values.
REQ-018 In WB, ADD (0000) and SUB (0001) SHALL write RF[Rdest] and update all 5 PSR bits.
REQ-019 In WB, CMP (0010) SHALL leave RF unchanged, update PSR L, Z and N, and retain C and F.
REQ-020 In WB, AND, OR, XOR, NOT, LSH, RSH, ARSH and MUL (0011-1010) SHALL write RF[Rdest] and leave the PSR unchanged.
REQ-021 Opcodes 1011-1111 SHALL pulse `illegal` in WB, with no RF write, no PSR change and no `wb_valid`.
REQ-022 `wb_valid` SHALL pulse for exactly one cycle (the WB cycle) on every RF write, and the RF contents SHALL be updated at the end of that cycle.
REQ-023 Latency SHALL be as follows: instruction accepted at edge N, `wb_valid` high in cycle N+3, and the next acceptance possible at edge N+4; throughput is one instruction per 4 cycles.
REQ-024 Instructions SHALL be strictly serial: there are no hazards and no forwarding, so the next READ sees the prior write.
REQ-025 `instr` SHALL be ignored while `instr_ready` = 0, and no buffering of offered instructions is performed.
REQ-026 Sampled ALU flags SHALL be masked per REQ-018 to REQ-020, so that undefined flag bits never reach the PSR.

Reset
REQ-027 On `reset` = 1 at a clock edge: state goes to IDLE, all RF entries = 0, `psr` = 0, `wb_valid` = 0, `illegal` = 0, ALU drive outputs = 0, and `instr_ready` = 1 in the following cycle.
REQ-028 A reset asserted in READ, EXEC or WB SHALL abort the instruction, with no RF write, no PSR update and no strobe.
REQ-029 `reset` SHALL take priority over a simultaneous `instr_valid`, so that the instruction is not accepted.

Structure
REQ-030 A shared package SHALL hold the opcode constants (ADD..MUL, values 0-10), the flag bit indices (C=0, L=1, F=2, Z=3, N=4), the FSM state encoding, and the instruction field positions.
REQ-031 The register file SHALL be a single sub-module, `regfile16x16`, with two synchronous-write/asynchronous-read ports plus the debug read port.
REQ-032 The ALU SHALL remain external to the block.

Verification
REQ-033 With R1 = 5 and R2 = 3, the bench SHALL check that ADD R2,R1 gives R2 = 8, `wb_valid` at N+3, `psr` C = 0 and Z = 0.
REQ-034 With R3 = 0x0004 and R4 = 0x0004, the bench SHALL check that CMP gives no `wb_valid`, R3 unchanged, `psr` Z = 1, L = 0, N = 0, and C/F equal to their prior values.
REQ-035 With R5 = 0xFFFF and R6 = 0x0001, the bench SHALL check that ADD gives R5 = 0x0000 and `psr` C = 1; a following XOR must leave `psr` unchanged.
REQ-036 The bench SHALL check that opcode 1100 gives an `illegal` pulse at N+3, no RF or PSR change, and `instr_ready` back high at N+4.
REQ-037 The bench SHALL check that reset asserted in EXEC of a SUB causes no writeback, `psr` = 0, all `dbg_data` = 0, and `instr_ready` = 1 on the next cycle.
REQ-038 The bench SHALL check that `instr_valid` held high for 8 cycles yields exactly 2 accepted instructions, at edges 0 and 4.

Source files
------------

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execution controller: opcodes, PSR flag
// positions, FSM encoding, instruction field positions and PSR update rules.
package alu_exec_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_RSH  = 4'd8;
  localparam logic [3:0] OP_ARSH = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RDEST_MSB = 11;
  localparam int RDEST_LSB = 8;
  localparam int RSRC_MSB  = 7;
  localparam int RSRC_LSB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // CMP refreshes only L/Z/N; C and F carry over from earlier arithmetic.
  localparam logic [4:0] CMP_UPD_MASK  = 5'((1 << FLAG_N) | (1 << FLAG_Z) | (1 << FLAG_L));
  localparam logic [4:0] CMP_KEEP_MASK = 5'((1 << FLAG_C) | (1 << FLAG_F));

  function automatic logic [3:0] field_op(input logic [15:0] i);
    return i[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] field_rdest(input logic [15:0] i);
    return i[RDEST_MSB:RDEST_LSB];
  endfunction

  function automatic logic [3:0] field_rsrc(input logic [15:0] i);
    return i[RSRC_MSB:RSRC_LSB];
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_MUL;
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    logic w;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_LSH, OP_RSH, OP_ARSH, OP_MUL: w = 1'b1;
      default:                         w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic [4:0] psr_next(input logic [3:0] op, input logic [4:0] cur,
                                          input logic [4:0] flags);
    logic [4:0] nxt;
    nxt = cur;
    if (op == OP_ADD || op == OP_SUB) begin
      nxt = flags;
    end else if (op == OP_CMP) begin
      nxt = (cur & CMP_KEEP_MASK) | (flags & CMP_UPD_MASK);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile16x16.sv
// 16 x 16-bit register file: two ports with synchronous write and
// asynchronous read, plus an asynchronous debug read port.
module regfile16x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_a,
  input  logic [3:0]  addr_a,
  input  logic [15:0] wdata_a,
  output logic [15:0] rdata_a,
  input  logic        we_b,
  input  logic [3:0]  addr_b,
  input  logic [15:0] wdata_b,
  output logic [15:0] rdata_b,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  logic [15:0] mem [16];

  // Port B wins when both ports write the same entry in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (we_b) mem[addr_b] <= wdata_b;
    end
  end

  assign rdata_a  = mem[addr_a];
  assign rdata_b  = mem[addr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-state serial controller: IDLE -> READ -> EXEC -> WB around an
// external ALU, owning the register file and the processor status flags.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_rsrc,
  output logic [15:0] alu_rdest,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        wb_valid,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output state_t      dbg_state
);
  // Handshake: an instruction moves when instr_valid & instr_ready are both
  // high at a rising edge; instr_ready is high only in IDLE, and nothing
  // offered while it is low is captured or remembered.
  state_t      state;
  logic [3:0]  op_q;
  logic [3:0]  rdest_q;
  logic [3:0]  rsrc_q;
  logic [4:0]  flags_q;
  logic [15:0] src_data;
  logic [15:0] dest_data;
  logic        unused_reserved;

  assign unused_reserved = ^instr[3:0];
  assign instr_ready     = (state == ST_IDLE);
  assign dbg_state       = state;

  // Port B addresses Rdest, so it serves both the operand read and the writeback.
  regfile16x16 u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_a     (1'b0),
    .addr_a   (rsrc_q),
    .wdata_a  (16'h0000),
    .rdata_a  (src_data),
    .we_b     (wb_valid),
    .addr_b   (rdest_q),
    .wdata_b  (wb_data),
    .rdata_b  (dest_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      rdest_q    <= '0;
      rsrc_q     <= '0;
      flags_q    <= '0;
      alu_opcode <= '0;
      alu_rsrc   <= '0;
      alu_rdest  <= '0;
      psr        <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      illegal    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= field_op(instr);
            rdest_q <= field_rdest(instr);
            rsrc_q  <= field_rsrc(instr);
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          // The ALU drive registers double as the operand latches.
          alu_opcode <= op_q;
          alu_rsrc   <= src_data;
          alu_rdest  <= dest_data;
          state      <= ST_EXEC;
        end
        ST_EXEC: begin
          wb_data  <= alu_out;
          flags_q  <= alu_flags;
          wb_addr  <= rdest_q;
          wb_valid <= op_writes(op_q);
          illegal  <= op_illegal(op_q);
          state    <= ST_WB;
        end
        ST_WB: begin
          psr   <= psr_next(op_q, psr, flags_q);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU, table of single-instruction
// vectors, hand-written corner sequences and a writeback scoreboard.
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_rsrc;
  logic [15:0] alu_rdest;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  state_t      dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_rsrc(alu_rsrc),
    .alu_rdest(alu_rdest), .alu_out(alu_out), .alu_flags(alu_flags), .psr(psr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ---------------- external ALU model ----------------
  logic        ovr_en;
  logic [15:0] ovr_val;

  // Returns {flags, result}; flags are {N,Z,F,L,C}. Non-arithmetic ops
  // return all-ones flags so any unmasked path shows up in the PSR.
  function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] dst,
                                            input logic [15:0] src);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic [4:0]  f;
    s = '0; p = '0; r = 16'hBEEF; f = 5'b11111;
    case (op)
      OP_ADD: begin
        s = {1'b0, dst} + {1'b0, src};
        r = s[15:0];
        f = '0;
        f[FLAG_C] = s[16];
        f[FLAG_F] = (dst[15] == src[15]) && (r[15] != dst[15]);
      end
      OP_SUB: begin
        r = dst - src;
        f = '0;
        f[FLAG_C] = dst < src;
        f[FLAG_F] = (dst[15] != src[15]) && (r[15] != dst[15]);
      end
      OP_CMP: begin
        r = 16'hDEAD;
        f = '0;
        f[FLAG_F] = 1'b1;
        f[FLAG_L] = dst < src;
        f[FLAG_Z] = dst == src;
        f[FLAG_N] = $signed(dst) < $signed(src);
      end
      OP_AND:  r = dst & src;
      OP_OR:   r = dst | src;
      OP_XOR:  r = dst ^ src;
      OP_NOT:  r = ~dst;
      OP_LSH:  r = dst << src[3:0];
      OP_RSH:  r = dst >> src[3:0];
      OP_ARSH: r = 16'($signed(dst) >>> src[3:0]);
      OP_MUL: begin
        p = dst * src;
        r = p[15:0];
      end
      default: r = 16'hBEEF;
    endcase
    if (op == OP_ADD || op == OP_SUB) begin
      f[FLAG_L] = dst < src;
      f[FLAG_Z] = r == 16'h0000;
      f[FLAG_N] = r[15];
    end
    return {f, r};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = alu_model(alu_opcode, alu_rdest, alu_rsrc);
    if (ovr_en) alu_out = ovr_val;
  end

  // ---------------- scoreboard / reference state ----------------
  logic [19:0] exp_q[$];
  logic [15:0] rf_m [16];
  logic [4:0]  psr_m;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {12'h0, wb_addr, wb_data}, 32'hFFFF_FFFF);
      end else begin
        check("wb_addr_data", {12'h0, wb_addr, wb_data}, {12'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    psr_m = '0;
    exp_q.delete();
  endtask

  task automatic model_issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                             input logic use_ovr, input logic [15:0] ovr,
                             input logic use_tbl, input logic [15:0] tbl,
                             output logic wr, output logic ill);
    logic [20:0] m;
    logic [15:0] res;
    m   = alu_model(op, rf_m[rd], rf_m[rs]);
    res = use_ovr ? ovr : m[15:0];
    if (use_tbl) res = tbl;
    wr  = (op <= OP_MUL) && (op != OP_CMP);
    ill = op > OP_MUL;
    if (wr) begin
      exp_q.push_back({rd, res});
      rf_m[rd] = res;
    end
    if (op == OP_ADD || op == OP_SUB) begin
      psr_m = m[20:16];
    end else if (op == OP_CMP) begin
      psr_m[FLAG_L] = m[16+FLAG_L];
      psr_m[FLAG_Z] = m[16+FLAG_Z];
      psr_m[FLAG_N] = m[16+FLAG_N];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_timeout", {31'h0, instr_ready}, 32'h1);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic use_ovr, input logic [15:0] ovr,
                           input logic use_tbl, input logic [15:0] tbl);
    logic wr, ill;
    wait_ready();
    ovr_en      = use_ovr;
    ovr_val     = ovr;
    instr       = {op, rd, rs, 4'h5};
    instr_valid = 1'b1;
    model_issue(op, rd, rs, use_ovr, ovr, use_tbl, tbl, wr, ill);
    @(posedge clk);                       // acceptance edge N
    @(negedge clk);
    instr_valid = 1'b0;
    check("busy_after_accept", {31'h0, instr_ready}, 32'h0);
    @(negedge clk);
    check("wb_early", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);                       // WB cycle
    check("wb_valid_n3", {31'h0, wb_valid}, {31'h0, wr});
    check("illegal_n3", {31'h0, illegal}, {31'h0, ill});
    @(negedge clk);
    check("ready_n4", {31'h0, instr_ready}, 32'h1);
    check("wb_one_cycle", {31'h0, wb_valid}, 32'h0);
    check("psr", {27'h0, psr}, {27'h0, psr_m});
    dbg_addr = rd;
    #1;
    check("rf_rdest", {16'h0, dbg_data}, {16'h0, rf_m[rd]});
    ovr_en = 1'b0;
  endtask

  task automatic load_reg(input logic [3:0] r, input logic [15:0] val);
    run_instr(OP_AND, r, r, 1'b1, val, 1'b0, 16'h0);
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check(name, {16'h0, dbg_data}, {16'h0, rf_m[i]});
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] a;     // preload of Rdest
    logic [15:0] b;     // preload of Rsrc
    logic [15:0] exp;   // expected Rdest after writeback
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [4:0] psr_before;
    int         acc_edge[$];

    vecs[0]  = '{OP_ADD,  4'd2,  4'd1,  16'h0003, 16'h0005, 16'h0008};
    vecs[1]  = '{OP_SUB,  4'd7,  4'd8,  16'h000A, 16'h0003, 16'h0007};
    vecs[2]  = '{OP_AND,  4'd9,  4'd10, 16'hF0F0, 16'hFF00, 16'hF000};
    vecs[3]  = '{OP_OR,   4'd9,  4'd10, 16'hF0F0, 16'h0F0F, 16'hFFFF};
    vecs[4]  = '{OP_XOR,  4'd11, 4'd12, 16'hAAAA, 16'hFFFF, 16'h5555};
    vecs[5]  = '{OP_NOT,  4'd11, 4'd12, 16'h00FF, 16'h1234, 16'hFF00};
    vecs[6]  = '{OP_LSH,  4'd13, 4'd14, 16'h0001, 16'h0004, 16'h0010};
    vecs[7]  = '{OP_RSH,  4'd13, 4'd14, 16'h8000, 16'h000F, 16'h0001};
    vecs[8]  = '{OP_ARSH, 4'd13, 4'd14, 16'h8000, 16'h0004, 16'hF800};
    vecs[9]  = '{OP_MUL,  4'd15, 4'd0,  16'h0003, 16'h0007, 16'h0015};
    vecs[10] = '{OP_SUB,  4'd1,  4'd1,  16'h0009, 16'h0009, 16'h0000};
    vecs[11] = '{OP_ADD,  4'd5,  4'd6,  16'hFFFF, 16'h0001, 16'h0000};

    // Reset with an instruction offered: reset must win.
    reset = 1'b1; instr_valid = 1'b1; instr = {OP_ADD, 4'd1, 4'd2, 4'h0};
    ovr_en = 1'b0; ovr_val = '0; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0; instr_valid = 1'b0;
    check("rst_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_psr", {27'h0, psr}, 32'h0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
    check("rst_alu_drive", {alu_opcode, alu_rsrc[11:0], alu_rdest}, 32'h0);
    check_all_regs("rst_rf");

    // Table of single instructions, each with fresh operand preloads.
    for (int v = 0; v < 12; v++) begin
      load_reg(vecs[v].rs, vecs[v].b);
      load_reg(vecs[v].rd, vecs[v].a);
      run_instr(vecs[v].op, vecs[v].rd, vecs[v].rs, 1'b0, 16'h0, 1'b1, vecs[v].exp);
    end
    check("add_wrap_carry", {31'h0, psr[FLAG_C]}, 32'h1);

    // A logic op right after the carry-out ADD must not touch the PSR.
    psr_before = psr_m;
    run_instr(OP_XOR, 4'd5, 4'd6, 1'b0, 16'h0, 1'b0, 16'h0);
    check("xor_psr_hold", {27'h0, psr}, {27'h0, psr_before});

    // CMP of equal values: no write, Z set, C/F retained.
    load_reg(4'd3, 16'h0004);
    load_reg(4'd4, 16'h0004);
    psr_before = psr_m;
    run_instr(OP_CMP, 4'd3, 4'd4, 1'b0, 16'h0, 1'b0, 16'h0);
    dbg_addr = 4'd3;
    #1;
    check("cmp_r3_kept", {16'h0, dbg_data}, 32'h0004);
    check("cmp_psr", {27'h0, psr},
          {27'h0, 1'b0, 1'b1, psr_before[FLAG_F], 1'b0, psr_before[FLAG_C]});

    // Illegal opcode: pulse only, no state change anywhere.
    psr_before = psr_m;
    run_instr(4'hC, 4'd3, 4'd4, 1'b0, 16'h0, 1'b0, 16'h0);
    check("illegal_psr_hold", {27'h0, psr}, {27'h0, psr_before});
    check_all_regs("illegal_rf_hold");

    // Reset during EXEC of a SUB aborts it completely.
    wait_ready();
    instr = {OP_SUB, 4'd2, 4'd1, 4'h0};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("state_exec", {30'h0, dbg_state}, {30'h0, ST_EXEC});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("abort_psr", {27'h0, psr}, 32'h0);
    check("abort_ready", {31'h0, instr_ready}, 32'h1);
    check_all_regs("abort_rf_clear");
    @(negedge clk);
    check("abort_no_late_wb", {31'h0, wb_valid}, 32'h0);

    // instr_valid held for 8 edges: only edges 0 and 4 accept.
    for (int k = 0; k < 8; k++) begin
      logic wr, ill;
      instr       = {OP_ADD, 4'(k + 1), 4'd0, 4'h0};
      instr_valid = 1'b1;
      if (instr_ready) begin
        acc_edge.push_back(k);
        model_issue(OP_ADD, 4'(k + 1), 4'd0, 1'b0, 16'h0, 1'b0, 16'h0, wr, ill);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("hold_accept_count", acc_edge.size(), 32'd2);
    if (acc_edge.size() >= 2) begin
      check("hold_accept_edge0", acc_edge[0], 32'd0);
      check("hold_accept_edge1", acc_edge[1], 32'd4);
    end
    repeat (5) @(negedge clk);
    check("hold_psr", {27'h0, psr}, {27'h0, psr_m});
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
